// File: rtl/exmem_wb_stage_reg.sv
// EX/MEM -> WB pipeline stage register for the 10-bit core.
// Carries the ALU result, RAM read data, write-back controls and the rt address
// into write-back. Supports stall hold, flush bubbles and a per-slot valid bit.
// Loads can hold the stage for MEM_WAIT extra cycles so slow RAM can deliver data.
module exmem_wb_stage_reg #(
   parameter int DATA_W   = 10,
   parameter int ADDR_W   = 3,
   parameter int MEM_WAIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] ram_rdata_in,
   input  logic              gp_reg_wb_in,
   input  logic              mem_re_in,
   input  logic [ADDR_W-1:0] gp_rdata2_address_in,
   input  logic              stall_in,
   input  logic              flush_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] ram_rdata_out,
   output logic              gp_reg_wb_out,
   output logic              mem_re_out,
   output logic [ADDR_W-1:0] gp_rdata2_address_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              wb_commit_out,
   output logic              stall_req_out,
   output logic              stall_out
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] WAIT_CYCLES = 4'(MEM_WAIT);

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_valid;
   logic [DATA_W-1:0]   r_alu;
   logic [DATA_W-1:0]   r_ram;
   logic                r_wb;
   logic                r_re;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_stall;
   logic                w_enterWait;

   // A valid load only needs to wait when the RAM is configured as slow.
   assign w_enterWait = valid_in & mem_re_in & (MEM_WAIT > 0);

   // Stage state machine: flush beats stall, stall freezes everything,
   // WAIT refreshes RAM data until the counter runs out, RUN captures new slots.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_alu   <= '0;
         r_ram   <= '0;
         r_wb    <= 1'b0;
         r_re    <= 1'b0;
         r_addr  <= '0;
      end else if (flush_in) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_alu   <= '0;
         r_ram   <= '0;
         r_wb    <= 1'b0;
         r_re    <= 1'b0;
         r_addr  <= '0;
      end else if (!stall_in) begin
         if (r_state == ST_WAIT) begin
            r_ram <= ram_rdata_in;
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_state <= ST_RUN;
            end
         end else begin
            r_valid <= valid_in;
            r_alu   <= alu_result_in;
            r_ram   <= ram_rdata_in;
            r_wb    <= gp_reg_wb_in & valid_in;
            r_re    <= mem_re_in & valid_in;
            r_addr  <= gp_rdata2_address_in;
            if (w_enterWait) begin
               r_state <= ST_WAIT;
               r_cnt   <= WAIT_CYCLES;
            end
         end
      end
   end

   // Delayed copy of the hazard stall for downstream bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall <= 1'b0;
      end else begin
         r_stall <= stall_in;
      end
   end

   assign valid_out             = r_valid;
   assign alu_result_out        = r_alu;
   assign ram_rdata_out         = r_ram;
   assign gp_reg_wb_out         = r_wb;
   assign mem_re_out            = r_re;
   assign gp_rdata2_address_out = r_addr;
   assign wb_data_out           = r_re ? r_ram : r_alu;
   assign wb_commit_out         = r_valid & r_wb & (r_state == ST_RUN);
   assign stall_req_out         = (r_state == ST_WAIT);
   assign stall_out             = r_stall;

endmodule
